// File: rtl/div_restoring.sv
// Multi-cycle restoring divider (IDLE -> RUN -> DONE), one quotient bit per
// clock, MSB first. Each trial subtraction adds the ones-complement of the
// divisor with carry-in 1.
// Optional feature macro: DIV_SIGNED_EN adds the signed_op input for
// two's-complement truncating division. The core stays unsigned; sign
// handling happens at the IDLE->RUN and RUN->DONE transitions.
module div_restoring #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef DIV_SIGNED_EN
  input  logic         signed_op,
`endif
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  r;      // partial remainder
  logic [N-1:0]  q;      // dividend shifting out / quotient shifting in
  logic [N-1:0]  d;      // latched divisor magnitude
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;
  logic          dbz_c;

  logic [N:0]    shifted;
  logic [N:0]    t;
  logic          borrow;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic          a_neg;
  logic          b_neg;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  // Operand magnitudes and sign flags presented at the accepted start
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    a_neg = 1'b0;
    b_neg = 1'b0;
`ifdef DIV_SIGNED_EN
    a_neg = signed_op & dividend[N-1];
    b_neg = signed_op & divisor[N-1];
    if (a_neg) a_mag = '0 - dividend;
    if (b_neg) b_mag = '0 - divisor;
`endif
  end

  // Trial subtraction. The full partial remainder is shifted (not just its
  // low N-1 bits) into an N+1-bit value: when the divisor exceeds 2^(N-1)
  // the remainder's top bit can be set, and bit N of the difference is then
  // still an exact borrow.
  always_comb begin
    shifted = {r, q[N-1]};
    t       = shifted + {1'b1, ~d} + {{N{1'b0}}, 1'b1};
    borrow  = t[N];
  end

  // Result sign correction; a zero divisor keeps the raw all-ones quotient
  always_comb begin
    q_fix = q;
    r_fix = r;
    if (neg_q && !dbz_c) q_fix = '0 - q;
    if (neg_r)           r_fix = '0 - r;
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_c       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            d     <= b_mag;
            r     <= '0;
            q     <= a_mag;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dbz_c <= (divisor == '0);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == CW'(N)) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= dbz_c;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            if (borrow) r <= shifted[N-1:0];
            else        r <= t[N-1:0];
            q   <= {q[N-2:0], ~borrow};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
